tx_hold_fifo: RTL and testbench
===============================

TX_HOLD_FIFO -- requirements
Module: tx_hold_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of one transmit word.
REQ-002 SHALL have parameter DEPTH, default 4, the number of storage entries; legal values are powers of two, 2 to 64.
REQ-003 SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ResetN, input, 1 bit, the reset; it is synchronous and active-low.
REQ-005 SHALL have port DataIn, input, DATA_WIDTH bits, the word offered for storage.
REQ-006 SHALL have port WrEn, input, 1 bit, the write request for DataIn.
REQ-007 SHALL have port DoneFlag, input, 1 bit, the transmitter done level; its rising edge requests the next word.
REQ-008 SHALL have port RegIn, output, DATA_WIDTH bits, the registered word currently handed to the transmitter.
REQ-009 SHALL have port Loaded, output, 1 bit, a one-cycle pulse when RegIn takes a new word.
REQ-010 SHALL have port Full, output, 1 bit, high when Count equals DEPTH.
REQ-011 SHALL have port Empty, output, 1 bit, high when Count equals 0.
REQ-012 SHALL have port Count, output, $clog2(DEPTH)+1 bits, the number of stored words, excluding RegIn.

Function
REQ-013 SHALL accept a write on a clock edge where WrEn=1 and Full=0; DataIn is stored at the tail.
REQ-014 SHALL drop a write where WrEn=1 and Full=1, even if a pop occurs in the same cycle.
REQ-015 SHALL detect a DoneFlag rising edge as DoneFlag=1 with the registered previous sample=0; a level held high SHALL produce exactly one request.
REQ-016 SHALL, on a detected request with Empty=0, load the head entry into RegIn, advance the read pointer, and assert Loaded on the next cycle for exactly one cycle.
REQ-017 SHALL, on a detected request with Empty=1, leave RegIn unchanged and leave Loaded low; the request is not remembered.
REQ-018 SHALL handle a request and an accepted write in the same cycle as follows: Count is unchanged, and both pointers advance.
REQ-019 SHALL handle a write to an empty FIFO in the same cycle as a request by accepting the write and performing no pop; Count goes to 1.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; Full and Empty SHALL derive from Count only.
REQ-021 SHALL register Full, Empty and Count, so they reflect state after the last edge; the write-to-Empty-deassert latency is 1 cycle.
REQ-022 SHALL hold RegIn stable between loads, whatever the FIFO contents.

Reset
REQ-023 SHALL, on a clock edge with ResetN=0, set RegIn=0, Loaded=0, Count=0, Empty=1 and Full=0, clear both pointers, and set the DoneFlag history register to 0.
REQ-024 SHALL, during a reset edge, ignore WrEn and DoneFlag; stored words are discarded, and storage contents need not be cleared.
REQ-025 SHALL, when DoneFlag=1 on the first edge after reset release, treat it as a rising edge.

Configuration
REQ-026 SHALL, with macro TX_HOLD_FIFO_ERR_EN defined, add input ClrErr (1 bit) and outputs Overflow and Underrun (1 bit each).
REQ-027 SHALL set Overflow sticky on a dropped write (REQ-014) and set Underrun sticky on an empty request (REQ-017).
REQ-028 SHALL clear Overflow and Underrun on ClrErr=1 or reset; a set event in the same cycle as ClrErr SHALL take priority.
REQ-029 SHALL, without TX_HOLD_FIFO_ERR_EN, have none of these ports, and all other behaviour SHALL be identical.

Structure
REQ-030 SHALL take the default DATA_WIDTH and DEPTH constants, and the count-width function, from shared package tx_pkg.
REQ-031 SHALL implement the DoneFlag rising-edge detection in sub-module tx_edge_det, with ports Clock, ResetN, In and Rise.

Verification
REQ-032 SHALL cover: reset, then write 0xA5, 0x3C; pulse DoneFlag twice -> RegIn=0xA5 then 0x3C, Loaded pulses twice, final Count=0, Empty=1.
REQ-033 SHALL cover: DEPTH=4; write 5 words 0x01..0x05 back-to-back -> Full=1 after the 4th, 0x05 dropped, Overflow=1 (macro on); subsequent pops yield 0x01..0x04.
REQ-034 SHALL cover: with Count=4, WrEn=1 and a DoneFlag edge in the same cycle -> the write is dropped, RegIn=head, Count=3.
REQ-035 SHALL cover: Empty=1; DoneFlag held high for 10 cycles -> no Loaded, RegIn unchanged, Underrun=1 once; then write 0x77 plus a new edge -> RegIn=0x77.
REQ-036 SHALL cover: with Count=2, ResetN=0 for 1 cycle mid-stream -> RegIn=0, Count=0, Empty=1; old words are never output.
REQ-037 SHALL cover: wrap-around, 3*DEPTH alternating write/pop of an incrementing pattern -> output order equals input order, with no loss.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared constants and helpers for the transmit hold FIFO.
// Default word width, depth and the Count width function.
package tx_pkg;

  localparam int TX_DATA_WIDTH = 8;
  localparam int TX_DEPTH      = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tx_edge_det.sv
// Rising-edge detector for the transmitter done level.
// History clears on reset so a high level just after release counts as a rise.
module tx_edge_det (
  input  logic Clock,
  input  logic ResetN,
  input  logic In,
  output logic Rise
);

  logic r_prev;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= In;
    end
  end

  assign Rise = In & ~r_prev;

endmodule

// File: rtl/tx_hold_fifo.sv
// Small FIFO feeding a registered word to a transmitter on each DoneFlag rise.
// Optional sticky Overflow/Underrun flags are enabled by TX_HOLD_FIFO_ERR_EN.
module tx_hold_fifo
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int DEPTH      = TX_DEPTH
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic [DATA_WIDTH-1:0]     DataIn,
  input  logic                      WrEn,
  input  logic                      DoneFlag,
  output logic [DATA_WIDTH-1:0]     RegIn,
  output logic                      Loaded,
  output logic                      Full,
  output logic                      Empty,
  output logic [cnt_w(DEPTH)-1:0]   Count
`ifdef TX_HOLD_FIFO_ERR_EN
  ,
  input  logic                      ClrErr,
  output logic                      Overflow,
  output logic                      Underrun
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_regin;
  logic                  r_loaded;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_rise;
  logic                  w_wr;
  logic                  w_pop;

  tx_edge_det u_edge (
    .Clock  (Clock),
    .ResetN (ResetN),
    .In     (DoneFlag),
    .Rise   (w_rise)
  );

  // Full drops the write even when a pop frees a slot this cycle.
  assign w_wr  = WrEn & ~r_full;
  assign w_pop = w_rise & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    unique case ({w_wr, w_pop})
      2'b10:   w_cnt_nxt = r_count + 1'b1;
      2'b01:   w_cnt_nxt = r_count - 1'b1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (ResetN && w_wr) begin
      r_mem[r_wptr] <= DataIn;
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_regin  <= '0;
      r_loaded <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_regin <= r_mem[r_rptr];
      end
      r_loaded <= w_pop;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == FULL_C);
      r_empty  <= (w_cnt_nxt == '0);
    end
  end

  assign RegIn  = r_regin;
  assign Loaded = r_loaded;
  assign Full   = r_full;
  assign Empty  = r_empty;
  assign Count  = r_count;

`ifdef TX_HOLD_FIFO_ERR_EN
  logic r_ovf;
  logic r_unr;

  // A set event wins over a same-cycle clear.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_ovf <= 1'b0;
      r_unr <= 1'b0;
    end else begin
      if (WrEn && r_full) begin
        r_ovf <= 1'b1;
      end else if (ClrErr) begin
        r_ovf <= 1'b0;
      end
      if (w_rise && r_empty) begin
        r_unr <= 1'b1;
      end else if (ClrErr) begin
        r_unr <= 1'b0;
      end
    end
  end

  assign Overflow = r_ovf;
  assign Underrun = r_unr;
`endif

endmodule

// File: tb/tb_tx_hold_fifo.sv
// Directed bench for tx_hold_fifo: vector table plus hand-written corner sequences.
// Error-flag checks are active when TX_HOLD_FIFO_ERR_EN is defined.
module tb_tx_hold_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       wr;
  logic       done;
  logic [7:0] regin;
  logic       loaded;
  logic       full;
  logic       empty;
  logic [2:0] count;
`ifdef TX_HOLD_FIFO_ERR_EN
  logic       clr_err;
  logic       ovf;
  logic       unr;
`endif

  int checks = 0;
  int errors = 0;

  tx_hold_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .Clock    (clk),
    .ResetN   (rst_n),
    .DataIn   (din),
    .WrEn     (wr),
    .DoneFlag (done),
    .RegIn    (regin),
    .Loaded   (loaded),
    .Full     (full),
    .Empty    (empty),
    .Count    (count)
`ifdef TX_HOLD_FIFO_ERR_EN
    ,
    .ClrErr   (clr_err),
    .Overflow (ovf),
    .Underrun (unr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       done;
    logic [7:0] din;
    logic [7:0] e_regin;
    logic       e_ld;
    logic       e_full;
    logic       e_empty;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  logic [7:0] mq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_st(input string nm, input logic [7:0] e_regin,
                        input logic e_ld, input logic e_empty,
                        input logic [2:0] e_cnt);
    chk({nm, " regin"}, 32'(regin), 32'(e_regin));
    chk({nm, " loaded"}, 32'(loaded), 32'(e_ld));
    chk({nm, " empty"}, 32'(empty), 32'(e_empty));
    chk({nm, " count"}, 32'(count), 32'(e_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    done  = 1'b0;
    din   = 8'h00;
`ifdef TX_HOLD_FIFO_ERR_EN
    clr_err = 1'b0;
`endif

    //          rst  wr   done din    regin  ld   F    E    cnt
    vq.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b1,3'd0});
    vq.push_back('{1'b1,1'b1,1'b0,8'hA5,8'h00,1'b0,1'b0,1'b0,3'd1});
    vq.push_back('{1'b1,1'b1,1'b0,8'h3C,8'h00,1'b0,1'b0,1'b0,3'd2});
    vq.push_back('{1'b1,1'b0,1'b1,8'h00,8'hA5,1'b1,1'b0,1'b0,3'd1});
    vq.push_back('{1'b1,1'b0,1'b0,8'h00,8'hA5,1'b0,1'b0,1'b0,3'd1});
    vq.push_back('{1'b1,1'b0,1'b1,8'h00,8'h3C,1'b1,1'b0,1'b1,3'd0});
    vq.push_back('{1'b1,1'b0,1'b0,8'h00,8'h3C,1'b0,1'b0,1'b1,3'd0});
    vq.push_back('{1'b1,1'b1,1'b0,8'h01,8'h3C,1'b0,1'b0,1'b0,3'd1});
    vq.push_back('{1'b1,1'b1,1'b0,8'h02,8'h3C,1'b0,1'b0,1'b0,3'd2});
    vq.push_back('{1'b1,1'b1,1'b0,8'h03,8'h3C,1'b0,1'b0,1'b0,3'd3});
    vq.push_back('{1'b1,1'b1,1'b0,8'h04,8'h3C,1'b0,1'b1,1'b0,3'd4});
    vq.push_back('{1'b1,1'b1,1'b0,8'h05,8'h3C,1'b0,1'b1,1'b0,3'd4});
    vq.push_back('{1'b1,1'b1,1'b1,8'h66,8'h01,1'b1,1'b0,1'b0,3'd3});
    vq.push_back('{1'b1,1'b0,1'b0,8'h00,8'h01,1'b0,1'b0,1'b0,3'd3});
    vq.push_back('{1'b1,1'b0,1'b1,8'h00,8'h02,1'b1,1'b0,1'b0,3'd2});
    vq.push_back('{1'b1,1'b0,1'b0,8'h00,8'h02,1'b0,1'b0,1'b0,3'd2});
    vq.push_back('{1'b1,1'b0,1'b1,8'h00,8'h03,1'b1,1'b0,1'b0,3'd1});
    vq.push_back('{1'b1,1'b0,1'b0,8'h00,8'h03,1'b0,1'b0,1'b0,3'd1});
    vq.push_back('{1'b1,1'b0,1'b1,8'h00,8'h04,1'b1,1'b0,1'b1,3'd0});
    vq.push_back('{1'b1,1'b0,1'b0,8'h00,8'h04,1'b0,1'b0,1'b1,3'd0});
    vq.push_back('{1'b1,1'b0,1'b1,8'h00,8'h04,1'b0,1'b0,1'b1,3'd0});
    vq.push_back('{1'b1,1'b0,1'b0,8'h00,8'h04,1'b0,1'b0,1'b1,3'd0});

    foreach (vq[i]) begin
      rst_n = vq[i].rst;
      wr    = vq[i].wr;
      done  = vq[i].done;
      din   = vq[i].din;
      tick();
      chk_st($sformatf("v%0d", i), vq[i].e_regin, vq[i].e_ld,
             vq[i].e_empty, vq[i].e_cnt);
      chk($sformatf("v%0d full", i), 32'(full), 32'(vq[i].e_full));
    end

`ifdef TX_HOLD_FIFO_ERR_EN
    chk("ovf after drop", 32'(ovf), 32'd1);
    chk("unr after empty req", 32'(unr), 32'd1);
    clr_err = 1'b1;
    tick();
    chk("ovf cleared", 32'(ovf), 32'd0);
    chk("unr cleared", 32'(unr), 32'd0);
    done = 1'b1;
    tick();
    chk("unr set beats clr", 32'(unr), 32'd1);
    chk("ovf stays clr", 32'(ovf), 32'd0);
    done = 1'b0;
    tick();
    chk("unr cleared again", 32'(unr), 32'd0);
    clr_err = 1'b0;
`endif

    // Held DoneFlag on an empty FIFO: one request only, nothing loaded.
    done = 1'b0;
    tick();
    for (int k = 1; k <= 10; k++) begin
      done = 1'b1;
`ifdef TX_HOLD_FIFO_ERR_EN
      clr_err = (k == 3);
`endif
      tick();
      chk_st($sformatf("hold%0d", k), 8'h04, 1'b0, 1'b1, 3'd0);
`ifdef TX_HOLD_FIFO_ERR_EN
      chk($sformatf("hold%0d unr", k), 32'(unr), (k < 3) ? 32'd1 : 32'd0);
`endif
    end
`ifdef TX_HOLD_FIFO_ERR_EN
    clr_err = 1'b0;
`endif
    wr  = 1'b1;
    din = 8'h77;
    tick();
    chk_st("w77 held", 8'h04, 1'b0, 1'b0, 3'd1);
    wr   = 1'b0;
    done = 1'b0;
    tick();
    chk_st("w77 fall", 8'h04, 1'b0, 1'b0, 3'd1);
    done = 1'b1;
    tick();
    chk_st("w77 load", 8'h77, 1'b1, 1'b1, 3'd0);

    // Write into empty FIFO together with a request: no pop.
    done = 1'b0;
    tick();
    wr   = 1'b1;
    din  = 8'h88;
    done = 1'b1;
    tick();
    chk_st("wr+req empty", 8'h77, 1'b0, 1'b0, 3'd1);
    wr   = 1'b0;
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
    chk_st("pop 88", 8'h88, 1'b1, 1'b1, 3'd0);
    done = 1'b0;

    // Mid-stream reset discards stored words.
    wr  = 1'b1;
    din = 8'h11;
    tick();
    din = 8'h22;
    tick();
    chk_st("pre rst", 8'h88, 1'b0, 1'b0, 3'd2);
    rst_n = 1'b0;
    din   = 8'h99;
    done  = 1'b1;
    tick();
    chk_st("rst", 8'h00, 1'b0, 1'b1, 3'd0);
    chk("rst full", 32'(full), 32'd0);
    rst_n = 1'b1;
    wr    = 1'b0;
    done  = 1'b0;
    tick();
    chk_st("post rst", 8'h00, 1'b0, 1'b1, 3'd0);
    wr  = 1'b1;
    din = 8'h33;
    tick();
    wr   = 1'b0;
    done = 1'b1;
    tick();
    chk_st("pop 33", 8'h33, 1'b1, 1'b1, 3'd0);
    done = 1'b0;

    // Wrap-around: alternating write/pop with one word of lag.
    wr  = 1'b1;
    din = 8'h40;
    mq.push_back(8'h40);
    tick();
    for (int i = 0; i < 12; i++) begin
      wr   = 1'b1;
      din  = 8'(8'h41 + i);
      done = 1'b0;
      mq.push_back(din);
      tick();
      chk($sformatf("wrap%0d count w", i), 32'(count), 32'(mq.size()));
      wr   = 1'b0;
      done = 1'b1;
      tick();
      chk($sformatf("wrap%0d regin", i), 32'(regin), 32'(mq.pop_front()));
      chk($sformatf("wrap%0d loaded", i), 32'(loaded), 32'd1);
      chk($sformatf("wrap%0d count p", i), 32'(count), 32'(mq.size()));
    end
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
    chk("wrap last", 32'(regin), 32'(mq.pop_front()));
    chk("wrap empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
